// File: rtl/i2s_tx.sv
// I2S serial transmitter: synchronizes the upstream word-select, holds one stereo frame, shifts it out MSB first.
// Optional build macro I2S_TX_HOLD_LAST_EN: on underrun repeat the last frame instead of sending silence.
module i2s_tx #(
    parameter int DATA_W   = 16,
    parameter int BCLK_DIV = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lrclk_in,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun
);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 2);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_W + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    logic              sync1_q, sync2_q, lr_q;
    logic              run_q, run_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              bclk_q, bclk_d, sdata_q, sdata_d, ur_q, ur_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic              hold_full_q, hold_full_d, ready_q, ready_d;
    logic [DATA_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              edge_det, fall, rise, accept;

    assign edge_det = sync2_q ^ lr_q;
    assign fall     = edge_det & ~sync2_q;
    assign rise     = edge_det & sync2_q;
    assign accept   = sample_valid & ready_q;

    always_comb begin
        run_d       = run_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sdata_d     = sdata_q;
        ur_d        = 1'b0;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        frame_l_d   = frame_l_q;
        frame_r_d   = frame_r_q;
        shift_d     = shift_q;

        if (fall) begin
            if (hold_full_q) begin
                frame_l_d   = hold_l_q;
                frame_r_d   = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                ur_d = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                frame_l_d = frame_l_q;
                frame_r_d = frame_r_q;
`else
                frame_l_d = '0;
                frame_r_d = '0;
`endif
            end
            shift_d = frame_l_d;
        end else if (rise) begin
            shift_d = frame_r_q;
        end

        // Accept happens only with hold empty, so it never collides with the drain above.
        if (accept) begin
            hold_l_d    = sample_l;
            hold_r_d    = sample_r;
            hold_full_d = 1'b1;
        end
        ready_d = ~hold_full_d;

        // Every word-select edge restarts the bit clock so BCLK stays phase-locked to LRCLK.
        if (edge_det) begin
            run_d   = 1'b1;
            div_d   = '0;
            bit_d   = '0;
            sdata_d = 1'b0;
        end else if (run_q) begin
            if (div_q == DIV_MAX) begin
                div_d = '0;
                if (bit_q != BIT_MAX) begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q < BIT_LAST) begin
                        sdata_d = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                    end else begin
                        sdata_d = 1'b0;
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        bclk_d = run_d && (div_d >= DIV_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            lr_q        <= 1'b0;
            run_q       <= 1'b0;
            div_q       <= '0;
            bit_q       <= '0;
            bclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            ur_q        <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            frame_l_q   <= '0;
            frame_r_q   <= '0;
            shift_q     <= '0;
        end else begin
            sync1_q     <= lrclk_in;
            sync2_q     <= sync1_q;
            lr_q        <= sync2_q;
            run_q       <= run_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            bclk_q      <= bclk_d;
            sdata_q     <= sdata_d;
            ur_q        <= ur_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
            shift_q     <= shift_d;
        end
    end

    assign sample_ready = ready_q;
    assign bclk         = bclk_q;
    assign lrclk        = lr_q;
    assign sdata        = sdata_q;
    assign underrun     = ur_q;
endmodule
